// File: rtl/weight_preload_seq.sv
// Weight preload sequencer for the conv0 kernel.
// Snapshots the packed kernel on a start pulse, then streams it one row per
// beat into the weight-stationary PE array over a valid/ready handshake.
// Rows go out highest index first so that, after KERNEL_HEIGHT shifts down the
// array columns, kernel row 0 ends up in the top PE row.
module weight_preload_seq #(
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int WEIGHT_WIDTH  = 8,
  localparam int ROW_W        = KERNEL_WIDTH * WEIGHT_WIDTH,
  localparam int IDX_W        = (KERNEL_HEIGHT > 1) ? $clog2(KERNEL_HEIGHT) : 1
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [KERNEL_HEIGHT*ROW_W-1:0]   weight_i,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic [ROW_W-1:0]                 row_data_o,
  output logic                             row_valid_o,
  input  logic                             row_ready_i,
  output logic [IDX_W-1:0]                 row_idx_o,
  output logic                             row_last_o,
  output logic                             done_o,
  output logic                             loaded_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] row_cnt, row_cnt_nxt;
  logic             loaded, loaded_nxt;
  logic             capture;

  // One row of the kernel per entry; row r already has column c at c*WEIGHT_WIDTH,
  // so a stored row is presented on row_data_o without any rearrangement.
  logic [ROW_W-1:0] snap [KERNEL_HEIGHT];

  // Next-state, counter and handshake outputs for the preload FSM.
  // NOTE: every output and next-state signal gets a default before the case so
  // no path through the block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    loaded_nxt  = loaded;
    capture     = 1'b0;
    busy_o      = 1'b0;
    row_valid_o = 1'b0;
    row_data_o  = '0;
    row_idx_o   = '0;
    row_last_o  = 1'b0;
    done_o      = 1'b0;

    case (state)
      IDLE: begin
        // A start here is also how a resident kernel gets reloaded.
        if (start_i) begin
          capture     = 1'b1;
          row_cnt_nxt = IDX_W'(KERNEL_HEIGHT - 1);
          loaded_nxt  = 1'b0;
          state_nxt   = SEND;
        end
      end

      SEND: begin
        busy_o      = 1'b1;
        row_valid_o = 1'b1;
        row_data_o  = snap[row_cnt];
        row_idx_o   = row_cnt;
        row_last_o  = (row_cnt == '0);
        // Without ready nothing moves, so the presented row stays stable.
        if (row_ready_i) begin
          if (row_cnt == '0) begin
            loaded_nxt = 1'b1;
            state_nxt  = DONE;
          end else begin
            row_cnt_nxt = row_cnt - IDX_W'(1);
          end
        end
      end

      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    loaded_o = loaded;
  end

  // State, row counter and loaded flag; reset overrides a preload in progress.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      row_cnt <= '0;
      loaded  <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      loaded  <= loaded_nxt;
    end
  end

  // Kernel snapshot: weight_i is sampled only on the cycle a start is accepted.
  // NOTE: this is a handful of flops rather than a RAM, so clearing it on reset
  // is cheap and keeps row_data_o free of stale weights after a reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int r = 0; r < KERNEL_HEIGHT; r++) begin
        snap[r] <= '0;
      end
    end else if (capture) begin
      for (int r = 0; r < KERNEL_HEIGHT; r++) begin
        snap[r] <= weight_i[r*ROW_W +: ROW_W];
      end
    end
  end

endmodule
